// File: rtl/mem_req_issue.sv
// MEM-stage issue side of the data-SRAM port: one outstanding req/addr_ok/data_ok transaction, result handed to WB.
// Optional macro ALIGN_CHECK_EN: misaligned half/word accesses raise out_ale instead of being force-aligned.
module mem_req_issue #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_result,
    input  logic [31:0]       in_wdata,
    input  logic [2:0]        in_store_op,
    input  logic [4:0]        in_load_op,
    input  logic              in_gr_we,
    input  logic [4:0]        in_dest,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [3:0]        data_sram_wstrb,
    output logic [31:0]       data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_result,
    output logic [31:0]       out_rdata,
    output logic [4:0]        out_load_op,
    output logic              out_res_from_mem,
    output logic              out_gr_we,
    output logic [4:0]        out_dest,
    output logic              out_ale
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t              r_state;
    logic                r_req;
    logic                r_wr;
    logic [1:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_wstrb;
    logic [31:0]         r_wdata;
    logic                r_out_valid;
    logic [31:0]         r_out_pc;
    logic [31:0]         r_out_result;
    logic [31:0]         r_out_rdata;
    logic [4:0]          r_out_load_op;
    logic                r_out_res_from_mem;
    logic                r_out_gr_we;
    logic [4:0]          r_out_dest;
    logic                r_out_ale;

    logic                w_is_store;
    logic                w_is_load;
    logic                w_is_byte;
    logic                w_is_half;
    logic                w_is_word;
    logic                w_trap;
    logic                w_issue;
    logic                w_accept;
    logic [1:0]          w_a;
    logic [1:0]          w_eff_a;
    logic [1:0]          w_size;
    logic [3:0]          w_wstrb;
    logic [31:0]         w_wdata;
    logic [31:0]         w_addr;

    // Access decode from the EX payload; the SRAM request fields are registered on accept.
    always_comb begin
        w_is_store = |in_store_op;
        w_is_load  = |in_load_op;
        w_is_byte  = in_store_op[0] | in_load_op[0] | in_load_op[3];
        w_is_half  = in_store_op[1] | in_load_op[1] | in_load_op[4];
        w_is_word  = in_store_op[2] | in_load_op[2];
        w_a        = in_result[1:0];
`ifdef ALIGN_CHECK_EN
        w_trap     = (w_is_half & w_a[0]) | (w_is_word & (w_a != 2'b00));
        w_eff_a    = w_a;
`else
        w_trap     = 1'b0;
        w_eff_a    = w_is_word ? 2'b00 : (w_is_half ? {w_a[1], 1'b0} : w_a);
`endif
        w_issue    = (w_is_store | w_is_load) & ~w_trap;
        w_addr     = {in_result[31:2], w_eff_a};
        w_size     = 2'd0;
        w_wstrb    = 4'b0000;
        w_wdata    = in_wdata;
        if (w_is_byte) begin
            w_size  = 2'd0;
            w_wstrb = 4'b0001 << w_eff_a;
            w_wdata = {4{in_wdata[7:0]}};
        end else if (w_is_half) begin
            w_size  = 2'd1;
            w_wstrb = 4'b0011 << w_eff_a;
            w_wdata = {2{in_wdata[15:0]}};
        end else if (w_is_word) begin
            w_size  = 2'd2;
            w_wstrb = 4'b1111;
        end
        if (!w_is_store) begin
            w_wstrb = 4'b0000;
        end
    end

    assign in_ready = (r_state == S_IDLE) & resetn;
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state            <= S_IDLE;
            r_req              <= 1'b0;
            r_wr               <= 1'b0;
            r_size             <= 2'd0;
            r_addr             <= '0;
            r_wstrb            <= 4'b0000;
            r_wdata            <= 32'd0;
            r_out_valid        <= 1'b0;
            r_out_pc           <= 32'd0;
            r_out_result       <= 32'd0;
            r_out_rdata        <= 32'd0;
            r_out_load_op      <= 5'd0;
            r_out_res_from_mem <= 1'b0;
            r_out_gr_we        <= 1'b0;
            r_out_dest         <= 5'd0;
            r_out_ale          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_out_pc           <= in_pc;
                        r_out_result       <= in_result;
                        r_out_rdata        <= 32'd0;
                        r_out_load_op      <= in_load_op;
                        r_out_res_from_mem <= w_is_load;
                        r_out_gr_we        <= in_gr_we & ~w_trap;
                        r_out_dest         <= in_dest;
                        r_out_ale          <= w_trap;
                        r_wr               <= w_is_store;
                        r_size             <= w_size;
                        r_addr             <= w_addr[ADDR_W-1:0];
                        r_wstrb            <= w_wstrb;
                        r_wdata            <= w_wdata;
                        if (w_issue) begin
                            r_req   <= 1'b1;
                            r_state <= S_REQ;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    // A flush cancels even if the SRAM accepts in the same cycle; its response is dropped in IDLE.
                    if (flush) begin
                        r_req   <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (data_sram_addr_ok) begin
                        r_req   <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        r_state <= data_sram_data_ok ? S_IDLE : S_DRAIN;
                    end else if (data_sram_data_ok) begin
                        if (r_out_res_from_mem) begin
                            r_out_rdata <= data_sram_rdata;
                        end
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DRAIN: begin
                    if (data_sram_data_ok) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (out_ready || flush) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_req       <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign data_sram_req    = r_req;
    assign data_sram_wr     = r_wr;
    assign data_sram_size   = r_size;
    assign data_sram_addr   = r_addr;
    assign data_sram_wstrb  = r_wstrb;
    assign data_sram_wdata  = r_wdata;
    assign out_valid        = r_out_valid;
    assign out_pc           = r_out_pc;
    assign out_result       = r_out_result;
    assign out_rdata        = r_out_rdata;
    assign out_load_op      = r_out_load_op;
    assign out_res_from_mem = r_out_res_from_mem;
    assign out_gr_we        = r_out_gr_we;
    assign out_dest         = r_out_dest;
    assign out_ale          = r_out_ale;

endmodule

// File: tb/tb_mem_req_issue.sv
// Testbench for mem_req_issue: directed corner cases plus randomized ops against a behavioural access model.
// Honours ALIGN_CHECK_EN the same way as the design when compiled with it.
module tb_mem_req_issue;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_result;
    logic [31:0] in_wdata;
    logic [2:0]  in_store_op;
    logic [4:0]  in_load_op;
    logic        in_gr_we;
    logic [4:0]  in_dest;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_result;
    logic [31:0] out_rdata;
    logic [4:0]  out_load_op;
    logic        out_res_from_mem;
    logic        out_gr_we;
    logic [4:0]  out_dest;
    logic        out_ale;

    int vecCount  = 0;
    int failCount = 0;

    mem_req_issue #(.ADDR_W(32)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_pc             (in_pc),
        .in_result         (in_result),
        .in_wdata          (in_wdata),
        .in_store_op       (in_store_op),
        .in_load_op        (in_load_op),
        .in_gr_we          (in_gr_we),
        .in_dest           (in_dest),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pc            (out_pc),
        .out_result        (out_result),
        .out_rdata         (out_rdata),
        .out_load_op       (out_load_op),
        .out_res_from_mem  (out_res_from_mem),
        .out_gr_we         (out_gr_we),
        .out_dest          (out_dest),
        .out_ale           (out_ale)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Illegal op encodings must never reach the design from this bench.
    always @(posedge clk) begin
        if (resetn && in_valid && in_ready) begin
            assert ($onehot0({in_store_op, in_load_op})) else begin
                failCount++;
                $error("[TB] FAIL onehot observed=%b_%b expected=one-hot", in_store_op, in_load_op);
            end
        end
    end

    // Op kinds: 0 none, 1 ST.B, 2 ST.H, 3 ST.W, 4 LB, 5 LH, 6 LW, 7 LBU, 8 LHU.
    function automatic int unsigned accessBytes(input int kind);
        case (kind)
            1, 4, 7: return 1;
            2, 5, 8: return 2;
            3, 6:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] storeOpOf(input int kind);
        case (kind)
            1:       return 3'b001;
            2:       return 3'b010;
            3:       return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [4:0] loadOpOf(input int kind);
        case (kind)
            4:       return 5'b00001;
            5:       return 5'b00010;
            6:       return 5'b00100;
            7:       return 5'b01000;
            8:       return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] pc, input logic [4:0] dest, input logic gwe);
        in_valid    = 1'b1;
        in_pc       = pc;
        in_result   = addr;
        in_wdata    = wdata;
        in_store_op = storeOpOf(kind);
        in_load_op  = loadOpOf(kind);
        in_gr_we    = gwe;
        in_dest     = dest;
    endtask

    // Full op: accept, SRAM handshake with the given delays, WB hold for dR cycles, then retire.
    task automatic runOp(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] pc, input logic [4:0] dest, input logic gwe,
                         input logic [31:0] rdata, input int dA, input int dD, input int dR);
        int unsigned bytes;
        logic        isLoad;
        logic        mis;
        logic        issue;
        logic [31:0] effAddr;
        logic [31:0] expWdata;
        logic [3:0]  expStrb;
        logic [1:0]  expSize;
        bytes  = accessBytes(kind);
        isLoad = (kind >= 4);
`ifdef ALIGN_CHECK_EN
        mis     = (bytes != 0) && ((addr % bytes) != 0);
        issue   = (bytes != 0) && !mis;
        effAddr = addr;
`else
        mis     = 1'b0;
        issue   = (bytes != 0);
        effAddr = (bytes != 0) ? addr - (addr % bytes) : addr;
`endif
        expSize  = (bytes == 1) ? 2'd0 : ((bytes == 2) ? 2'd1 : 2'd2);
        expStrb  = (!isLoad && bytes != 0) ? 4'(((1 << bytes) - 1) << effAddr[1:0]) : 4'b0000;
        expWdata = wdata;
        if (bytes != 0) begin
            for (int j = 0; j < 4; j++) begin
                expWdata[j*8 +: 8] = wdata[(j % bytes)*8 +: 8];
            end
        end

        checkOutput("accept_ready", in_ready, 1'b1);
        applyStimulus(kind, addr, wdata, pc, dest, gwe);
        tick();
        in_valid = 1'b0;
        checkOutput("busy_ready", in_ready, 1'b0);
        if (issue) begin
            checkOutput("req", data_sram_req, 1'b1);
            checkOutput("wr", data_sram_wr, !isLoad);
            checkOutput("size", data_sram_size, expSize);
            checkOutput("addr", data_sram_addr, effAddr);
            checkOutput("wstrb", data_sram_wstrb, expStrb);
            if (!isLoad) begin
                checkOutput("wdata", data_sram_wdata, expWdata);
            end
            for (int i = 0; i < dA; i++) begin
                tick();
                checkOutput("req_hold", data_sram_req, 1'b1);
            end
            data_sram_addr_ok = 1'b1;
            tick();
            data_sram_addr_ok = 1'b0;
            checkOutput("req_drop", data_sram_req, 1'b0);
            for (int i = 0; i < dD; i++) begin
                tick();
                checkOutput("wait_novalid", out_valid, 1'b0);
            end
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = rdata;
            tick();
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = $urandom();
        end else begin
            checkOutput("no_req", data_sram_req, 1'b0);
        end
        for (int i = 0; i <= dR; i++) begin
            checkOutput("out_valid", out_valid, 1'b1);
            checkOutput("out_pc", out_pc, pc);
            checkOutput("out_result", out_result, addr);
            checkOutput("out_rdata", out_rdata, isLoad ? rdata : 32'd0);
            checkOutput("out_load_op", out_load_op, loadOpOf(kind));
            checkOutput("out_res_from_mem", out_res_from_mem, isLoad);
            checkOutput("out_gr_we", out_gr_we, gwe & !mis);
            checkOutput("out_dest", out_dest, dest);
            checkOutput("out_ale", out_ale, mis);
            if (i == dR) begin
                out_ready = 1'b1;
            end
            tick();
        end
        out_ready = 1'b0;
        checkOutput("retire_drop", out_valid, 1'b0);
        checkOutput("retire_idle", in_ready, 1'b1);
    endtask

    initial begin
        int          kind;
        logic [31:0] a;
        resetn            = 1'b0;
        flush             = 1'b0;
        in_valid          = 1'b0;
        in_pc             = 32'd0;
        in_result         = 32'd0;
        in_wdata          = 32'd0;
        in_store_op       = 3'd0;
        in_load_op        = 5'd0;
        in_gr_we          = 1'b0;
        in_dest           = 5'd0;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        out_ready         = 1'b0;

        #2;
        checkOutput("rst_req", data_sram_req, 1'b0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b0);
        checkOutput("rst_out_pc", out_pc, 32'd0);
        checkOutput("rst_out_rdata", out_rdata, 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        checkOutput("rst_release_ready", in_ready, 1'b1);

        // T1: ST.B byte lane 3, req held two cycles.
        runOp(1, 32'h0000_1003, 32'h1122_3344, 32'h0000_0100, 5'd3, 1'b0, 32'h0, 1, 1, 0);
        // T2: LH with WB back-pressure.
        runOp(5, 32'h0000_2002, 32'h0, 32'h0000_0104, 5'd7, 1'b1, 32'hBEEF_1234, 0, 1, 3);

        // T3: flush while waiting for LW data; drain until the late data_ok.
        applyStimulus(6, 32'h0000_4000, 32'h0, 32'h0000_0108, 5'd9, 1'b1);
        tick();
        in_valid = 1'b0;
        checkOutput("t3_req", data_sram_req, 1'b1);
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t3_busy", in_ready, 1'b0);
            checkOutput("t3_novalid", out_valid, 1'b0);
            if (i == 1) begin
                flush = 1'b1;
            end
            tick();
            flush = 1'b0;
        end
        checkOutput("t3_busy_last", in_ready, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        tick();
        data_sram_data_ok = 1'b0;
        checkOutput("t3_idle", in_ready, 1'b1);
        checkOutput("t3_novalid_end", out_valid, 1'b0);

        // T4: flush coinciding with addr_ok, then a stray data_ok in IDLE.
        applyStimulus(4, 32'h0000_5001, 32'h0, 32'h0000_010C, 5'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        checkOutput("t4_req", data_sram_req, 1'b1);
        data_sram_addr_ok = 1'b1;
        flush             = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        flush             = 1'b0;
        checkOutput("t4_req_drop", data_sram_req, 1'b0);
        checkOutput("t4_idle", in_ready, 1'b1);
        data_sram_data_ok = 1'b1;
        tick();
        data_sram_data_ok = 1'b0;
        checkOutput("t4_stray_valid", out_valid, 1'b0);
        checkOutput("t4_stray_idle", in_ready, 1'b1);
        runOp(0, 32'h0000_7777, 32'h0, 32'h0000_0110, 5'd5, 1'b1, 32'h0, 0, 0, 0);

        // T5: misaligned ST.W.
        runOp(3, 32'h0000_3002, 32'hA1B2_C3D4, 32'h0000_0114, 5'd6, 1'b1, 32'h0, 0, 2, 1);

        // Flush while the result waits for WB.
        applyStimulus(0, 32'h0000_0042, 32'h0, 32'h0000_0118, 5'd8, 1'b1);
        tick();
        in_valid = 1'b0;
        checkOutput("fd_valid", out_valid, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("fd_drop", out_valid, 1'b0);
        checkOutput("fd_idle", in_ready, 1'b1);

        // T6: asynchronous reset in the middle of a WAIT.
        applyStimulus(6, 32'h0000_6004, 32'h0, 32'hCAFE_0000, 5'd10, 1'b1);
        tick();
        in_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        #3;
        resetn = 1'b0;
        #1;
        checkOutput("t6_req", data_sram_req, 1'b0);
        checkOutput("t6_out_valid", out_valid, 1'b0);
        checkOutput("t6_out_pc", out_pc, 32'd0);
        checkOutput("t6_out_result", out_result, 32'd0);
        checkOutput("t6_in_ready", in_ready, 1'b0);
        tick();
        resetn = 1'b1;
        #1;
        checkOutput("t6_idle", in_ready, 1'b1);
        tick();
        checkOutput("t6_idle_valid", out_valid, 1'b0);

        // Randomized mix of all op kinds, addresses and handshake delays.
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 8));
            a    = $urandom();
            runOp(kind, a, $urandom(), $urandom(), 5'($urandom()), 1'($urandom()), $urandom(),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
